// File: rtl/coin_pulse_front_end.sv
// Front end for the vending FSM: synchronises and debounces the nickel/dime
// chute sensors, then arbitrates them into one-cycle N / D / reject pulses.
module coin_pulse_front_end #(
  parameter int DB_LEN     = 4,
  parameter int DB_W       = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic nickel_raw,
  input  logic dime_raw,
  input  logic inhibit,
  output logic N,
  output logic D,
  output logic reject,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } arbState_e;

  localparam logic [DB_W-1:0] DbLast  = DB_W'(DB_LEN - 1);
  localparam logic [3:0]      GapLoad = 4'(GAP_CYCLES);

  // Channel index 0 is the nickel sensor, index 1 the dime sensor.
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           dbLvl_q, dbLvl_d;
  logic [1:0]           dbPrev_q;
  logic [1:0][DB_W-1:0] dbCnt_q, dbCnt_d;
  logic [1:0]           coinEv;

  arbState_e state_q, state_d;
  logic [3:0] gapCnt_q, gapCnt_d;
  logic       nPulse_q, nPulse_d;
  logic       dPulse_q, dPulse_d;
  logic       rejPulse_q, rejPulse_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      dbLvl_q  <= '0;
      dbPrev_q <= '0;
      dbCnt_q  <= '0;
    end else begin
      sync1_q  <= {dime_raw, nickel_raw};
      sync2_q  <= sync1_q;
      dbLvl_q  <= dbLvl_d;
      dbPrev_q <= dbLvl_q;
      dbCnt_q  <= dbCnt_d;
    end
  end

  // A level change is accepted only after DB_LEN consecutive disagreeing samples.
  always_comb begin
    dbLvl_d = dbLvl_q;
    dbCnt_d = dbCnt_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] == dbLvl_q[ch]) begin
        dbCnt_d[ch] = '0;
      end else if (dbCnt_q[ch] == DbLast) begin
        dbLvl_d[ch] = ~dbLvl_q[ch];
        dbCnt_d[ch] = '0;
      end else begin
        dbCnt_d[ch] = dbCnt_q[ch] + DB_W'(1);
      end
    end
  end

  assign coinEv = dbLvl_q & ~dbPrev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gapCnt_q   <= '0;
      nPulse_q   <= 1'b0;
      dPulse_q   <= 1'b0;
      rejPulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gapCnt_q   <= gapCnt_d;
      nPulse_q   <= nPulse_d;
      dPulse_q   <= dPulse_d;
      rejPulse_q <= rejPulse_d;
    end
  end

  // Any coin that arrives while a previous one is still being spaced out is returned.
  always_comb begin
    state_d    = state_q;
    gapCnt_d   = gapCnt_q;
    nPulse_d   = 1'b0;
    dPulse_d   = 1'b0;
    rejPulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (coinEv == 2'b11) begin
          rejPulse_d = 1'b1;
        end else if (coinEv != 2'b00) begin
          if (inhibit) begin
            rejPulse_d = 1'b1;
          end else begin
            nPulse_d = coinEv[0];
            dPulse_d = coinEv[1];
            state_d  = PULSE;
          end
        end
      end
      PULSE: begin
        rejPulse_d = |coinEv;
        state_d    = GAP;
        gapCnt_d   = GapLoad;
      end
      GAP: begin
        rejPulse_d = |coinEv;
        if (gapCnt_q == 4'd1) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign N      = nPulse_q;
  assign D      = dPulse_q;
  assign reject = rejPulse_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_coin_pulse_front_end.sv
// Scoreboard bench for coin_pulse_front_end: a cycle-level reference model predicts
// every N/D/reject pulse and the busy level, a negedge monitor compares the DUT.
module tb_coin_pulse_front_end;

  localparam int DB_LEN     = 4;
  localparam int DB_W       = 3;
  localparam int GAP_CYCLES = 2;

  logic clk        = 1'b0;
  logic reset      = 1'b0;
  logic nickel_raw = 1'b0;
  logic dime_raw   = 1'b0;
  logic inhibit    = 1'b0;
  logic N, D, reject, busy;

  int checks = 0;
  int errors = 0;

  coin_pulse_front_end #(
    .DB_LEN(DB_LEN),
    .DB_W(DB_W),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .nickel_raw(nickel_raw),
    .dime_raw(dime_raw),
    .inhibit(inhibit),
    .N(N),
    .D(D),
    .reject(reject),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } expOut_t;

  expOut_t expQ[$];
  expOut_t monEntry;

  int         cyc = 0;
  int         lastPulse = -1000;
  logic [1:0] mS1, mS2, mLvl, mPrev, mEv;
  int         mRun[2];
  logic [2:0] mCode;
  bit         mBusy;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic failNow(input string name, input int expCyc, input logic [2:0] expCode);
    checks++;
    errors++;
    $display("[TB] FAIL %s at cycle %0d: got NDR=%b expected NDR=%b at cycle %0d",
             name, cyc, {N, D, reject}, expCode, expCyc);
  endtask

  // Reference model: raw samples pass through two delay stages, a level only
  // changes after a run of DB_LEN disagreeing samples, and a rising level is a coin.
  // A coin is accepted when the arbiter has been quiet long enough since the last pulse.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mS1       = '0;
      mS2       = '0;
      mLvl      = '0;
      mPrev     = '0;
      mRun[0]   = 0;
      mRun[1]   = 0;
      lastPulse = -1000;
      expQ.delete();
    end else begin
      cyc++;
      mEv   = mLvl & ~mPrev;
      mCode = 3'b000;
      if (mEv != 2'b00) begin
        if (mEv == 2'b11 || inhibit || cyc < lastPulse + GAP_CYCLES + 2) begin
          mCode = 3'b001;
        end else begin
          mCode     = mEv[0] ? 3'b100 : 3'b010;
          lastPulse = cyc;
        end
      end
      if (mCode != 3'b000) expQ.push_back('{cyc, mCode});
      mPrev = mLvl;
      for (int ch = 0; ch < 2; ch++) begin
        if (mS2[ch] != mLvl[ch]) begin
          mRun[ch]++;
          if (mRun[ch] == DB_LEN) begin
            mLvl[ch] = ~mLvl[ch];
            mRun[ch] = 0;
          end
        end else begin
          mRun[ch] = 0;
        end
      end
      mS2 = mS1;
      mS1 = {dime_raw, nickel_raw};
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("resetOutputs", {N, D, reject, busy}, 4'b0000);
    end else begin
      mBusy = (cyc >= lastPulse) && (cyc <= lastPulse + GAP_CYCLES);
      checkOutput("busy", busy, mBusy);
      if ({N, D, reject} != 3'b000) begin
        if (expQ.size() == 0) begin
          failNow("unexpectedPulse", cyc, 3'b000);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("pulseCycle", cyc, monEntry.cyc);
          checkOutput("pulseCode", {N, D, reject}, monEntry.code);
        end
      end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
        monEntry = expQ.pop_front();
        failNow("missedPulse", monEntry.cyc, monEntry.code);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic nick, input logic dime, input logic inh, input int n);
    nickel_raw = nick;
    dime_raw   = dime;
    inhibit    = inh;
    step(n);
  endtask

  initial begin
    $display("[TB] start");
    #1 reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);

    // Clean nickel, then a bouncy dime, then a short glitch that must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 15);

    // Simultaneous coins, then inhibited and uninhibited dimes.
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 12);
    applyStimulus(1'b0, 1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);

    // Dime lands in the gap after a nickel and is returned.
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);

    // Reset during the gap, then a normal dime.
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    reset      = 1'b1;
    nickel_raw = 1'b0;
    step(2);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);

    // Nickel held high across reset release gives exactly one coin.
    nickel_raw = 1'b1;
    reset      = 1'b1;
    step(2);
    reset = 1'b0;
    step(14);
    applyStimulus(1'b0, 1'b0, 1'b0, 20);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) nickel_raw = ~nickel_raw;
      if ($urandom_range(5) == 0) dime_raw = ~dime_raw;
      if ($urandom_range(7) == 0) inhibit = ~inhibit;
      reset = ($urandom_range(999) == 0);
      step(1);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 30);

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
